// File: rtl/regfile.sv
// Integer register file: 2**ADDR_WIDTH x DATA_WIDTH, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, optional write-first bypass.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] readPort1SEL,
  input  logic [ADDR_WIDTH-1:0] readPort2SEL,
  input  logic [ADDR_WIDTH-1:0] writePortSEL,
  input  logic [DATA_WIDTH-1:0] writePort,
  output logic [DATA_WIDTH-1:0] readPort1,
  output logic [DATA_WIDTH-1:0] readPort2
);
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;

  assign wr_en = WE && (writePortSEL != '0);

  // x0 is cleared by reset and never written; the read mux also forces it to zero
  // so it reads 0 even before the first reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[writePortSEL] <= writePort;
    end
  end

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rsel;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;

  assign rsel = {readPort2SEL, readPort1SEL};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    logic hit;
    // Bypass ignores rst on purpose: only the store is blocked by reset.
    assign hit      = (BYPASS != 0) && wr_en && (writePortSEL == rsel[p]);
    assign rdata[p] = hit               ? writePort :
                      (rsel[p] == '0)   ? '0        : regs[rsel[p]];
  end

  assign readPort1 = rdata[0];
  assign readPort2 = rdata[1];
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  s1, s2, ws;
  logic [31:0] wd;
  logic [31:0] r1b, r2b, r1n, r2n;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .WE(we), .readPort1SEL(s1), .readPort2SEL(s2),
    .writePortSEL(ws), .writePort(wd), .readPort1(r1b), .readPort2(r2b));

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .WE(we), .readPort1SEL(s1), .readPort2SEL(s2),
    .writePortSEL(ws), .writePort(wd), .readPort1(r1n), .readPort2(r2n));

  typedef struct {
    logic        rst, we;
    logic [4:0]  ws, s1, s2;
    logic [31:0] wd, e1, e2, n1, n2;
    string       nm;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive at negedge, sample 1 time unit later; the following posedge commits.
  task automatic drive(input logic r, input logic w, input logic [4:0] wsel,
                       input logic [31:0] wdat, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst = r; we = w; ws = wsel; wd = wdat; s1 = a; s2 = b;
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return (i == 0) ? 32'h0 : 32'h1000_0000 + i;
  endfunction

  initial begin
    rst = 1'b0; we = 1'b0; ws = '0; wd = '0; s1 = '0; s2 = '0;

    //           rst we ws s1 s2 wd            byp r1        byp r2        nob r1        nob r2
    vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        "x0_pre_reset"};
    vecs[1]  = '{0, 1, 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        "wr_x1"};
    vecs[2]  = '{0, 0, 0, 1, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h0,        "rd_x1_p1"};
    vecs[3]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, "rd_x1_p2"};
    vecs[4]  = '{0, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, "wr_x0"};
    vecs[5]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, "x0_after"};
    vecs[6]  = '{0, 1, 5, 2, 3, 32'h11111111, 32'h0,        32'h0,        32'h0,        32'h0,        "wr_x5_init"};
    vecs[7]  = '{0, 1, 5, 5, 5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111, 32'h11111111, "bypass_x5"};
    vecs[8]  = '{0, 0, 0, 5, 5, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, "after_x5"};
    vecs[9]  = '{0, 1, 3, 3, 1, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, "wr_x3"};
    vecs[10] = '{1, 1, 3, 3, 5, 32'hCAFEF00D, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, "rst_prio"};
    vecs[11] = '{0, 0, 0, 3, 5, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        "x3_cleared"};
    vecs[12] = '{0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        "x1_cleared"};

    // First vector is the reset; sweep all registers right after it.
    drive(vecs[0].rst, vecs[0].we, vecs[0].ws, vecs[0].wd, vecs[0].s1, vecs[0].s2);
    chk({vecs[0].nm, "_b1"}, r1b, vecs[0].e1);
    chk({vecs[0].nm, "_n1"}, r1n, vecs[0].n1);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
      chk($sformatf("rst_sweep_b1_%0d", i), r1b, 32'h0);
      chk($sformatf("rst_sweep_b2_%0d", i), r2b, 32'h0);
      chk($sformatf("rst_sweep_n1_%0d", i), r1n, 32'h0);
      chk($sformatf("rst_sweep_n2_%0d", i), r2n, 32'h0);
    end

    for (int v = 1; v < 13; v++) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].ws, vecs[v].wd, vecs[v].s1, vecs[v].s2);
      chk({vecs[v].nm, "_b1"}, r1b, vecs[v].e1);
      chk({vecs[v].nm, "_b2"}, r2b, vecs[v].e2);
      chk({vecs[v].nm, "_n1"}, r1n, vecs[v].n1);
      chk({vecs[v].nm, "_n2"}, r2n, vecs[v].n2);
    end

    // Full sweep from a clean reset: bypass shows new data, stored side still 0.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 32; i++) begin
      drive(0, 1, 5'(i), sweep_val(i), 5'(i), 0);
      chk($sformatf("sweep_wr_b1_%0d", i), r1b, sweep_val(i));
      chk($sformatf("sweep_wr_n1_%0d", i), r1n, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
      chk($sformatf("sweep_rd_b1_%0d", i), r1b, sweep_val(i));
      chk($sformatf("sweep_rd_b2_%0d", i), r2b, sweep_val(31 - i));
      chk($sformatf("sweep_rd_n1_%0d", i), r1n, sweep_val(i));
      chk($sformatf("sweep_rd_n2_%0d", i), r2n, sweep_val(31 - i));
    end

    // Dual-port bypass hit on a stored register, and WE=0 leaves contents alone.
    drive(0, 1, 7, 32'h0BADC0DE, 7, 7);
    chk("dual_hit_b1", r1b, 32'h0BADC0DE);
    chk("dual_hit_b2", r2b, 32'h0BADC0DE);
    chk("dual_hit_n1", r1n, 32'h1000_0007);
    drive(0, 0, 8, 32'hFFFF0000, 7, 8);
    chk("we0_b1", r1b, 32'h0BADC0DE);
    chk("we0_b2", r2b, 32'h1000_0008);
    drive(0, 0, 0, 0, 8, 7);
    chk("we0_after_n1", r1n, 32'h1000_0008);
    chk("we0_after_n2", r2n, 32'h0BADC0DE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
